// File: rtl/baseaddr_loop_n_pkg.sv
// Shared constants and helpers for the frame-buffer base-address manager.
package baseaddr_pkg;

  localparam int NBUF_MAX = 16;
  localparam int NRD_MAX  = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Saturating increment for a counter that is cw bits wide (cw <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int cw);
    logic [31:0] maxVal;
    maxVal = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    return (cnt >= maxVal) ? maxVal : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/baseaddr_loop_n_if.sv
// Vsync inputs and base-address outputs of the frame-buffer manager.
interface baseaddr_loop_n_if
  import baseaddr_pkg::*;
#(
  parameter int NBUF = 5,
  parameter int NRD  = 3,
  parameter int CW   = 16
);
  localparam int AW = clog2(NBUF);

  logic              wr_vs;
  logic [NRD-1:0]    rd_vs;
  logic [NRD-1:0]    rd_en;
  logic [AW-1:0]     wr_base;
  logic [NRD*AW-1:0] rd_base;
  logic [NRD-1:0]    rd_valid;
  logic [NRD-1:0]    rd_repeat;
  logic [AW-1:0]     latest_base;
  logic              latest_vld;
  logic              drop_pulse;
  logic [CW-1:0]     drop_cnt;

  modport master (
    output wr_vs, rd_vs, rd_en,
    input  wr_base, rd_base, rd_valid, rd_repeat,
    input  latest_base, latest_vld, drop_pulse, drop_cnt
  );

  modport slave (
    input  wr_vs, rd_vs, rd_en,
    output wr_base, rd_base, rd_valid, rd_repeat,
    output latest_base, latest_vld, drop_pulse, drop_cnt
  );
endinterface

// File: rtl/baseaddr_loop_n_free_buf_pick.sv
// Combinational priority encoder: lowest buffer index not set in the exclusion mask.
module free_buf_pick
  import baseaddr_pkg::*;
#(
  parameter int NBUF = 5,
  parameter int AW   = clog2(NBUF)
) (
  input  logic [NBUF-1:0] i_mask,
  output logic [AW-1:0]   o_idx,
  output logic            o_found
);

  // Scanning downwards lets the lowest free index win.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int b = NBUF - 1; b >= 0; b--) begin
      if (!i_mask[b]) begin
        o_idx   = AW'(b);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/baseaddr_loop_n.sv
// Frame-buffer base-address manager: one writer, NRD readers, drop detection.
module baseaddr_loop_n
  import baseaddr_pkg::*;
#(
  parameter int NBUF = 5,
  parameter int NRD  = 3,
  parameter int CW   = 16
) (
  input logic               clk,
  input logic               rst_n,
  baseaddr_loop_n_if.slave  bus
);
  localparam int AW = clog2(NBUF);

  logic                    r_wr_vs_d;
  logic [NRD-1:0]          r_rd_vs_d;
  logic [AW-1:0]           r_wr_base;
  logic [NRD-1:0][AW-1:0]  r_rd_base;
  logic [NRD-1:0]          r_rd_valid;
  logic [NRD-1:0]          r_rd_repeat;
  logic [AW-1:0]           r_latest_base;
  logic                    r_latest_vld;
  logic                    r_drop_pulse;
  logic [CW-1:0]           r_drop_cnt;

  logic                    w_wr_edge;
  logic [NRD-1:0]          w_rd_edge;
  logic [NBUF-1:0]         w_excl;
  logic [AW-1:0]           w_free_idx;
  logic                    w_found;
  logic                    w_commit;
  logic [AW-1:0]           w_latest_nxt;
  logic                    w_latest_vld_nxt;

  assign w_wr_edge = bus.wr_vs & ~r_wr_vs_d;
  assign w_rd_edge = bus.rd_vs & ~r_rd_vs_d & bus.rd_en;

  // A reader taking this cycle lands on the current wr_base, already excluded,
  // so only readers that keep their old holding contribute their rd_base.
  always_comb begin
    w_excl = '0;
    for (int b = 0; b < NBUF; b++) begin
      if (r_wr_base == AW'(b)) w_excl[b] = 1'b1;
      for (int i = 0; i < NRD; i++) begin
        if (bus.rd_en[i] && r_rd_valid[i] && !w_rd_edge[i] && (r_rd_base[i] == AW'(b)))
          w_excl[b] = 1'b1;
      end
    end
  end

  free_buf_pick #(.NBUF(NBUF), .AW(AW)) u_pick (
    .i_mask  (w_excl),
    .o_idx   (w_free_idx),
    .o_found (w_found)
  );

  assign w_commit         = w_wr_edge & w_found;
  assign w_latest_nxt     = w_commit ? r_wr_base : r_latest_base;
  assign w_latest_vld_nxt = r_latest_vld | w_commit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_vs_d     <= 1'b0;
      r_rd_vs_d     <= '0;
      r_wr_base     <= '0;
      r_rd_base     <= '0;
      r_rd_valid    <= '0;
      r_rd_repeat   <= '0;
      r_latest_base <= '0;
      r_latest_vld  <= 1'b0;
      r_drop_pulse  <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      r_wr_vs_d     <= bus.wr_vs;
      r_rd_vs_d     <= bus.rd_vs;
      r_latest_base <= w_latest_nxt;
      r_latest_vld  <= w_latest_vld_nxt;
      r_drop_pulse  <= w_wr_edge & ~w_found;
      if (w_commit)
        r_wr_base <= w_free_idx;
      if (w_wr_edge && !w_found)
        r_drop_cnt <= CW'(sat_inc(32'(r_drop_cnt), CW));
      for (int i = 0; i < NRD; i++) begin
        r_rd_repeat[i] <= 1'b0;
        if (!bus.rd_en[i]) begin
          r_rd_valid[i] <= 1'b0;
        end else if (w_rd_edge[i] && w_latest_vld_nxt) begin
          r_rd_base[i]   <= w_latest_nxt;
          r_rd_valid[i]  <= 1'b1;
          r_rd_repeat[i] <= r_rd_valid[i] && (r_rd_base[i] == w_latest_nxt);
        end
      end
    end
  end

  assign bus.wr_base     = r_wr_base;
  assign bus.rd_base     = r_rd_base;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_repeat   = r_rd_repeat;
  assign bus.latest_base = r_latest_base;
  assign bus.latest_vld  = r_latest_vld;
  assign bus.drop_pulse  = r_drop_pulse;
  assign bus.drop_cnt    = r_drop_cnt;

endmodule
